vga_frame_checker: RTL
======================

// Module: vga_frame_checker
// PURPOSE
//  Receive end of the VGA link: samples the hSync/vSync/vgaR/G/B outputs of vga_top on the
//  system clock and rebuilds pixel/line position from the sync edges. Checks 640x480@60 timing,
//  accumulates a 24-bit checksum of active pixels per frame, and reports lock and errors.
//  Used as an on-chip self-check and as the golden monitor in vga_top benches.
// PARAMETERS
//  CLK_DIV 4 system clocks per pixel | H_SYNC 96 | H_BP 48 | H_ACT 640 | H_TOTAL 800 (pixels)
//  V_SYNC 2 | V_BP 33 | V_ACT 480 | V_TOTAL 525 (lines) | LOCK_FRAMES 2 good frames to lock
// PORTS
//  ClkPort     in   1   system clock (100 MHz)
//  Reset       in   1   synchronous, active-high reset
//  hSync       in   1   horizontal sync, active low
//  vSync       in   1   vertical sync, active low
//  vgaR/G/B    in   4 each  pixel colour, packed internally as rgb = {R,G,B}
//  frame_done  out  1   one-cycle pulse: complete error-free frame checked
//  frame_sum   out  24  checksum of last complete frame, held until next frame_done
//  locked      out  1   LOCK_FRAMES consecutive good frames seen
//  h_err       out  1   one-cycle pulse: horizontal timing violation
//  v_err       out  1   one-cycle pulse: vertical timing violation
// BEHAVIOUR
//  - Reset: all outputs 0, counters 0, state WAIT_VS. Reset mid-frame aborts frame, no pulses.
//  - Inputs registered once (d1), then again (d2); fall = d2 & ~d1, rise = ~d2 & d1.
//  - Pixel strobe: asserted on hSync-fall cycle and every CLK_DIV clocks after; div counter
//    restarts on every hSync fall. hcnt = 0 on fall strobe, +1 per strobe, saturates at H_TOTAL.
//  - Line: vcnt += 1 on each hSync fall. vSync fall sets vs_pend; next hSync fall (or the same
//    cycle) clears vs_pend and loads vcnt = 0 instead of incrementing.
//  - Active pixel: vcnt in [V_SYNC+V_BP, +V_ACT) and hcnt in [H_SYNC+H_BP, +H_ACT); on its strobe
//    acc <= acc + {12'b0, rgb_d1} (mod 2^24).
//  - FSM WAIT_VS: ignore checks; on vs_pend consumption -> TRACK, acc = 0, no frame_done.
//  - FSM TRACK checks (each violation: pulse h_err or v_err for 1 cycle, locked <= 0,
//    good_cnt <= 0, acc <= 0, state -> WAIT_VS; same-cycle h and v errors both pulse):
//      h: hSync fall with hcnt != H_TOTAL-1 (except first fall after entering TRACK);
//         hSync rise with hcnt != H_SYNC; hcnt reaching H_TOTAL (missing sync).
//      v: vs_pend consumed with vcnt != V_TOTAL-1; vcnt reaching V_TOTAL.
//  - Frame end (vs_pend consumed in TRACK, no error): frame_sum <= acc, frame_done pulse same
//    cycle as frame_sum update, acc <= 0, good_cnt sat-increments; locked <= 1 when
//    good_cnt+1 >= LOCK_FRAMES. locked stays 1 until an error or Reset.
//  - Latency: frame_done = 3 clocks after the vSync-fall-qualified hSync fall at inputs.
//  - Widths: hcnt 10b, vcnt 10b, div 2b (clog2 CLK_DIV), good_cnt 3b saturating.
// CONFIGURATION
//  VGA_CHK_ERRCNT_EN defined: adds output err_cnt [7:0], +1 per cycle with h_err|v_err,
//    saturates at 8'hFF, cleared only by Reset.
//  Undefined: no err_cnt port or logic; all other behaviour identical.
// TESTING
//  1 Ideal 640x480 timing, rgb=12'h001 every pixel, 3 frames -> frame_done x2 (not on first
//    vSync), frame_sum=24'h04B000, locked=1 at 2nd frame_done, no errors.
//  2 Same timing, rgb=12'hFFF -> frame_sum=24'hFB5000; rgb=0 -> 24'h000000.
//  3 Locked stream, one line with H_TOTAL=799 -> h_err 1 pulse, locked=0, no frame_done that
//    frame; relocks after 2 further good frames (frame_done of 1st good one only, locked on 2nd).
//  4 Locked stream, one frame with 524 lines -> v_err 1 pulse at vSync, locked=0.
//  5 Reset asserted mid-frame for 1 cycle -> all outputs 0 next cycle; next vSync gives no
//    frame_done; following frame gives correct frame_sum.
//  6 VGA_CHK_ERRCNT_EN: 300 injected h errors -> err_cnt=8'hFF; Reset -> 0.

Source files
------------

// File: rtl/vga_frame_checker.sv
// VGA receive-side monitor: rebuilds pixel/line position from sync edges, checks timing,
// checksums active pixels per frame. Define VGA_CHK_ERRCNT_EN to add the err_cnt output.
module vga_frame_checker #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned H_ACT       = 640,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned V_ACT       = 480,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic        hSync,
    input  logic        vSync,
    input  logic [3:0]  vgaR,
    input  logic [3:0]  vgaG,
    input  logic [3:0]  vgaB,
    output logic        frame_done,
    output logic [23:0] frame_sum,
    output logic        locked,
    output logic        h_err,
    output logic        v_err
`ifdef VGA_CHK_ERRCNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0] HTotal = 10'(H_TOTAL);
    localparam logic [9:0] HLast  = 10'(H_TOTAL - 1);
    localparam logic [9:0] HSyncW = 10'(H_SYNC);
    localparam logic [9:0] HActLo = 10'(H_SYNC + H_BP);
    localparam logic [9:0] HActHi = 10'(H_SYNC + H_BP + H_ACT);
    localparam logic [9:0] VTotal = 10'(V_TOTAL);
    localparam logic [9:0] VLast  = 10'(V_TOTAL - 1);
    localparam logic [9:0] VActLo = 10'(V_SYNC + V_BP);
    localparam logic [9:0] VActHi = 10'(V_SYNC + V_BP + V_ACT);
    localparam logic [3:0] LockN  = 4'(LOCK_FRAMES);

    typedef enum logic [0:0] {StWaitVs, StTrack} state_e;

    state_e          state;
    logic            hs_d1, hs_d2, vs_d1, vs_d2;
    logic [11:0]     rgb_d1;
    logic [DivW-1:0] div;
    logic [9:0]      hcnt, vcnt;
    logic            vs_pend;
    logic            first_fall;
    logic [23:0]     acc;
    logic [2:0]      good_cnt;

    logic            h_fall, h_rise, v_fall, strobe, vs_take, active;
    logic            herr_now, verr_now, frame_end;
    logic [DivW-1:0] div_base, div_next;
    logic [9:0]      hcnt_next, vcnt_next;

    always_comb begin
        h_fall   = hs_d2 & ~hs_d1;
        h_rise   = ~hs_d2 & hs_d1;
        v_fall   = vs_d2 & ~vs_d1;
        strobe   = h_fall | (div == '0);
        vs_take  = h_fall & (vs_pend | v_fall);

        // Pixel phase is re-anchored on every hSync fall.
        div_base = h_fall ? '0 : div;
        div_next = (div_base == DivW'(CLK_DIV - 1)) ? '0 : div_base + DivW'(1);

        hcnt_next = hcnt;
        if (h_fall) begin
            hcnt_next = '0;
        end else if (strobe && hcnt != HTotal) begin
            hcnt_next = hcnt + 10'd1;
        end

        vcnt_next = vcnt;
        if (vs_take) begin
            vcnt_next = '0;
        end else if (h_fall && vcnt != VTotal) begin
            vcnt_next = vcnt + 10'd1;
        end

        active = strobe && (vcnt_next >= VActLo) && (vcnt_next < VActHi) &&
                 (hcnt_next >= HActLo) && (hcnt_next < HActHi);

        herr_now = 1'b0;
        verr_now = 1'b0;
        if (state == StTrack) begin
            if (h_fall && !first_fall && hcnt != HLast) herr_now = 1'b1;
            if (h_rise && hcnt_next != HSyncW) herr_now = 1'b1;
            if (strobe && !h_fall && hcnt == HLast) herr_now = 1'b1;
            if (vs_take && vcnt != VLast) verr_now = 1'b1;
            if (h_fall && !vs_take && vcnt == VLast) verr_now = 1'b1;
        end
        frame_end = (state == StTrack) && vs_take && !herr_now && !verr_now;
    end

    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            state      <= StWaitVs;
            hs_d1      <= 1'b0;
            hs_d2      <= 1'b0;
            vs_d1      <= 1'b0;
            vs_d2      <= 1'b0;
            rgb_d1     <= '0;
            div        <= '0;
            hcnt       <= '0;
            vcnt       <= '0;
            vs_pend    <= 1'b0;
            first_fall <= 1'b0;
            acc        <= '0;
            good_cnt   <= '0;
            frame_done <= 1'b0;
            frame_sum  <= '0;
            locked     <= 1'b0;
            h_err      <= 1'b0;
            v_err      <= 1'b0;
`ifdef VGA_CHK_ERRCNT_EN
            err_cnt    <= '0;
`endif
        end else begin
            hs_d1      <= hSync;
            hs_d2      <= hs_d1;
            vs_d1      <= vSync;
            vs_d2      <= vs_d1;
            rgb_d1     <= {vgaR, vgaG, vgaB};
            div        <= div_next;
            hcnt       <= hcnt_next;
            vcnt       <= vcnt_next;
            frame_done <= 1'b0;
            h_err      <= herr_now;
            v_err      <= verr_now;

            if (vs_take) begin
                vs_pend <= 1'b0;
            end else if (v_fall) begin
                vs_pend <= 1'b1;
            end

            if (active) begin
                acc <= acc + {12'b0, rgb_d1};
            end

            case (state)
                StWaitVs: begin
                    if (vs_take) begin
                        state      <= StTrack;
                        acc        <= '0;
                        first_fall <= 1'b1;
                    end
                end
                StTrack: begin
                    if (h_fall) begin
                        first_fall <= 1'b0;
                    end
                    if (herr_now || verr_now) begin
                        state    <= StWaitVs;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                        acc      <= '0;
                    end else if (frame_end) begin
                        frame_sum  <= acc;
                        frame_done <= 1'b1;
                        acc        <= '0;
                        if (good_cnt != 3'h7) begin
                            good_cnt <= good_cnt + 3'd1;
                        end
                        if (({1'b0, good_cnt} + 4'd1) >= LockN) begin
                            locked <= 1'b1;
                        end
                    end
                end
                default: state <= StWaitVs;
            endcase

`ifdef VGA_CHK_ERRCNT_EN
            if ((herr_now || verr_now) && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
`endif
        end
    end

endmodule
